// File: rtl/decode_ctrl.sv
// decode_ctrl: walks one Kyber byte-array object out of a 64-bit source RAM,
// feeds the decode bit-unpacker through a 2-entry prefetch FIFO and tags its output words.
module decode_ctrl #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [1:0]    i_mode,
    input  logic [2:0]    i_k,
    input  logic          i_du,
    input  logic          i_dv,
    input  logic [AW-1:0] i_base_addr,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [63:0]   i_rd_data,
    output logic [3:0]    o_dec_l,
    output logic [63:0]   o_dec_ibytes,
    output logic          o_dec_ibytes_valid,
    input  logic          i_dec_ibytes_ready,
    input  logic [63:0]   i_dec_coeffs,
    input  logic          i_dec_coeffs_valid,
    input  logic          i_dec_done,
    output logic [63:0]   o_coeffs,
    output logic          o_coeffs_valid,
    output logic [2:0]    o_poly_idx,
    output logic [5:0]    o_word_idx,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // Bit width of polynomial idx within an object of the given mode.
    function automatic logic [3:0] poly_l(input logic [1:0] mode, input logic [2:0] k,
                                          input logic du, input logic dv,
                                          input logic [2:0] idx);
        logic [3:0] l;
        case (mode)
            2'd0:    l = 4'd12;
            2'd1:    l = (idx < k) ? (du ? 4'd11 : 4'd10) : (dv ? 4'd5 : 4'd4);
            default: l = 4'd1;
        endcase
        return l;
    endfunction

    state_t        state_reg, state_next;
    logic [1:0]    mode_reg, mode_next;
    logic [2:0]    k_reg, k_next;
    logic          du_reg, du_next;
    logic          dv_reg, dv_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [2:0]    poly_reg, poly_next;
    logic [3:0]    l_reg, l_next;
    logic [5:0]    issued_reg, issued_next;
    logic [5:0]    xfer_reg, xfer_next;
    logic          err_reg, err_next;
    logic          done_reg;

    logic [63:0]   fifo_mem [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg, count_next;
    logic          rd_pend_reg;

    logic          cv_reg;
    logic [2:0]    poly_out_reg;
    logic [5:0]    word_reg;

    logic [2:0]    n_polys;
    logic [5:0]    words;
    logic          head_valid;
    logic [63:0]   head;
    logic          pop;
    logic          push;
    logic [2:0]    occ;
    logic          rd_en;
    logic          legal_start;

    always_comb begin
        case (mode_reg)
            2'd0:    n_polys = k_reg;
            2'd1:    n_polys = k_reg + 3'd1;
            default: n_polys = 3'd1;
        endcase
    end

    assign words       = {l_reg, 2'b00};
    assign legal_start = (i_mode != 2'd3) && (i_k >= 3'd2) && (i_k <= 3'd4);

    // The word returning from the RAM this cycle is presented directly when the
    // FIFO is empty, so the first valid appears one cycle after the first read.
    assign head_valid = (count_reg != 2'd0) || rd_pend_reg;
    assign head       = (count_reg != 2'd0) ? fifo_mem[rd_ptr_reg] :
                        (rd_pend_reg ? i_rd_data : 64'd0);
    assign pop        = head_valid && i_dec_ibytes_ready && (state_reg == S_FEED);
    assign push       = rd_pend_reg && !(pop && (count_reg == 2'd0));

    // Occupancy after this cycle's pop, counting the read still in flight.
    assign occ   = {1'b0, count_reg} + {2'b00, rd_pend_reg} - {2'b00, pop};
    assign rd_en = ((state_reg == S_SETUP) || (state_reg == S_FEED)) &&
                   (occ < 3'd2) && (issued_reg < words);
    assign count_next = count_reg + {1'b0, rd_pend_reg} - {1'b0, pop};

    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        k_next      = k_reg;
        du_next     = du_reg;
        dv_next     = dv_reg;
        addr_next   = addr_reg;
        poly_next   = poly_reg;
        l_next      = l_reg;
        issued_next = issued_reg;
        xfer_next   = xfer_reg;
        err_next    = err_reg;

        if (rd_en) begin
            addr_next   = addr_reg + AW'(1);
            issued_next = issued_reg + 6'd1;
        end
        if (pop) begin
            xfer_next = xfer_reg + 6'd1;
        end

        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    mode_next = i_mode;
                    k_next    = i_k;
                    du_next   = i_du;
                    dv_next   = i_dv;
                    err_next  = !legal_start;
                    if (legal_start) begin
                        addr_next   = i_base_addr;
                        poly_next   = 3'd0;
                        l_next      = poly_l(i_mode, i_k, i_du, i_dv, 3'd0);
                        issued_next = 6'd0;
                        xfer_next   = 6'd0;
                        state_next  = S_SETUP;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_SETUP: state_next = S_FEED;
            S_FEED: begin
                if (pop && (xfer_reg == words - 6'd1)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_dec_done) begin
                    if ((poly_reg + 3'd1) < n_polys) begin
                        poly_next   = poly_reg + 3'd1;
                        l_next      = poly_l(mode_reg, k_reg, du_reg, dv_reg, poly_reg + 3'd1);
                        issued_next = 6'd0;
                        xfer_next   = 6'd0;
                        state_next  = S_SETUP;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= S_IDLE;
            mode_reg     <= 2'd0;
            k_reg        <= 3'd0;
            du_reg       <= 1'b0;
            dv_reg       <= 1'b0;
            addr_reg     <= '0;
            poly_reg     <= 3'd0;
            l_reg        <= 4'd0;
            issued_reg   <= 6'd0;
            xfer_reg     <= 6'd0;
            err_reg      <= 1'b0;
            done_reg     <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            rd_pend_reg  <= 1'b0;
            cv_reg       <= 1'b0;
            poly_out_reg <= 3'd0;
            word_reg     <= 6'd0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            k_reg        <= k_next;
            du_reg       <= du_next;
            dv_reg       <= dv_next;
            addr_reg     <= addr_next;
            poly_reg     <= poly_next;
            l_reg        <= l_next;
            issued_reg   <= issued_next;
            xfer_reg     <= xfer_next;
            err_reg      <= err_next;
            done_reg     <= (state_reg == S_DONE);
            count_reg    <= count_next;
            rd_pend_reg  <= rd_en;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop && (count_reg != 2'd0)) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            // decode registers its coefficient data one cycle behind its valid
            cv_reg       <= i_dec_coeffs_valid;
            poly_out_reg <= poly_reg;
            if (state_reg == S_SETUP) begin
                word_reg <= 6'd0;
            end else if (cv_reg) begin
                word_reg <= word_reg + 6'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= i_rd_data;
        end
    end

    assign o_rd_en            = rd_en;
    assign o_rd_addr          = addr_reg;
    assign o_dec_l            = l_reg;
    assign o_dec_ibytes       = head;
    assign o_dec_ibytes_valid = head_valid;
    assign o_coeffs           = cv_reg ? i_dec_coeffs : 64'd0;
    assign o_coeffs_valid     = cv_reg;
    assign o_poly_idx         = poly_out_reg;
    assign o_word_idx         = word_reg;
    assign o_busy             = (state_reg != S_IDLE);
    assign o_done             = done_reg;
    assign o_err              = err_reg;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: random-stall bench for decode_ctrl with a behavioural decode
// stand-in, a source RAM model and an object-level reference of reads, transfers and tags.
module tb_decode_ctrl;

    localparam int AW     = 8;
    localparam int NC     = 32;    // coefficient words the decode stand-in returns per poly
    localparam int BUDGET = 4000;

    typedef struct {
        logic [2:0]  p;
        logic [5:0]  w;
        logic [63:0] d;
    } coef_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start;
    logic [1:0]    mode;
    logic [2:0]    k;
    logic          du;
    logic          dv;
    logic [AW-1:0] base;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data = 64'd0;
    logic [3:0]    dec_l;
    logic [63:0]   dec_ibytes;
    logic          dec_valid;
    logic          dec_ready;
    logic [63:0]   dec_coeffs;
    logic          dec_cv;
    logic          dec_done;
    logic [63:0]   coeffs;
    logic          coeffs_valid;
    logic [2:0]    poly_idx;
    logic [5:0]    word_idx;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [63:0] ram [256];
    coef_t       exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    decode_ctrl #(.AW(AW)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_mode             (mode),
        .i_k                (k),
        .i_du               (du),
        .i_dv               (dv),
        .i_base_addr        (base),
        .o_rd_en            (rd_en),
        .o_rd_addr          (rd_addr),
        .i_rd_data          (rd_data),
        .o_dec_l            (dec_l),
        .o_dec_ibytes       (dec_ibytes),
        .o_dec_ibytes_valid (dec_valid),
        .i_dec_ibytes_ready (dec_ready),
        .i_dec_coeffs       (dec_coeffs),
        .i_dec_coeffs_valid (dec_cv),
        .i_dec_done         (dec_done),
        .o_coeffs           (coeffs),
        .o_coeffs_valid     (coeffs_valid),
        .o_poly_idx         (poly_idx),
        .o_word_idx         (word_idx),
        .o_busy             (busy),
        .o_done             (done),
        .o_err              (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"},    64'(rd_en), 64'd0);
        check({tag, "_rd_addr"},  64'(rd_addr), 64'd0);
        check({tag, "_dec_l"},    64'(dec_l), 64'd0);
        check({tag, "_ibytes"},   dec_ibytes, 64'd0);
        check({tag, "_ivalid"},   64'(dec_valid), 64'd0);
        check({tag, "_coeffs"},   coeffs, 64'd0);
        check({tag, "_cvalid"},   64'(coeffs_valid), 64'd0);
        check({tag, "_poly_idx"}, 64'(poly_idx), 64'd0);
        check({tag, "_word_idx"}, 64'(word_idx), 64'd0);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_done"},     64'(done), 64'd0);
        check({tag, "_err"},      64'(err), 64'd0);
    endtask

    task automatic run_obj(input logic [1:0] m, input logic [2:0] kk, input logic u,
                           input logic v, input logic [AW-1:0] b, input bit stall,
                           input bit abort);
        int            lens [$];
        int            total;
        bit            legal;
        int            cyc;
        int            rd_cnt, xf_cnt, poly_xf, mpoly, dphase, wait_cnt, em_cnt, didx;
        int            done_cnt, done_cyc, gap_ref, seen_done_at, coef_cnt;
        bit            prev_cv, prev_stall, gap_pending, done_now;
        logic [63:0]   prev_bytes;
        logic [63:0]   cdata;
        logic [AW-1:0] a;
        coef_t         e;

        legal = (m != 2'd3) && (kk >= 3'd2) && (kk <= 3'd4);
        if (legal) begin
            case (m)
                2'd0: for (int i = 0; i < int'(kk); i++) lens.push_back(12);
                2'd1: begin
                    for (int i = 0; i < int'(kk); i++) lens.push_back(u ? 11 : 10);
                    lens.push_back(v ? 5 : 4);
                end
                default: lens.push_back(1);
            endcase
        end
        total = 0;
        foreach (lens[i]) total += 4 * lens[i];

        rd_cnt = 0; xf_cnt = 0; poly_xf = 0; mpoly = 0; wait_cnt = 0; em_cnt = 0; didx = 0;
        done_cnt = 0; done_cyc = -100; gap_ref = 0; seen_done_at = -1; coef_cnt = 0;
        dphase = legal ? 0 : 3;
        prev_cv = 0; prev_stall = 0; gap_pending = legal; prev_bytes = '0;
        exp_q.delete();

        @(negedge clk);
        start = 1'b1; mode = m; k = kk; du = u; dv = v; base = b;
        dec_ready = 1'b0; dec_cv = 1'b0; dec_done = 1'b0; dec_coeffs = '0;
        #1;
        check("idle_busy", 64'(busy), 64'd0);

        for (cyc = 1; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            // decode stand-in: stalls ready while feeding, returns NC words, then done
            dec_ready  = (dphase == 0) ? (stall ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
            dec_cv     = 1'b0;
            dec_done   = 1'b0;
            dec_coeffs = '0;
            done_now   = 0;
            if (prev_cv) begin
                cdata      = {$urandom(), $urandom()};
                dec_coeffs = cdata;
                e.p = 3'(mpoly); e.w = 6'(didx); e.d = cdata;
                exp_q.push_back(e);
                didx++;
            end
            if (dphase == 2) begin
                if (em_cnt < NC) begin
                    dec_cv = 1'b1;
                    em_cnt++;
                end else begin
                    dec_done = 1'b1;
                    done_now = 1;
                end
            end else if (dphase == 1) begin
                if (wait_cnt == 0) dphase = 2;
                else wait_cnt--;
            end
            prev_cv = dec_cv;

            #1;
            if (cyc == 1) begin
                check("setup_busy", 64'(busy), 64'd1);
                check("err_at_start", 64'(err), 64'(!legal));
                check("setup_rd_en", 64'(rd_en), 64'(legal));
            end
            if (rd_en) begin
                a = b + AW'(rd_cnt);
                check("rd_addr", 64'(rd_addr), 64'(a));
                rd_cnt++;
                if (rd_cnt > total) check("rd_overrun", 64'(rd_cnt), 64'(total));
            end
            if (prev_stall) begin
                check("hold_valid", 64'(dec_valid), 64'd1);
                check("hold_data", dec_ibytes, prev_bytes);
            end
            if (mpoly < lens.size()) check("dec_l", 64'(dec_l), 64'(lens[mpoly]));
            if (dec_valid && gap_pending) begin
                check("first_valid", 64'(cyc), 64'(gap_ref + 2));
                gap_pending = 0;
            end
            if (!stall && dphase == 0 && poly_xf > 0) check("stream", 64'(dec_valid), 64'd1);
            if (dec_valid && dphase != 0) check("spurious_valid", 64'(dec_valid), 64'd0);
            if (dec_valid && dec_ready) begin
                a = b + AW'(xf_cnt);
                check("xfer_data", dec_ibytes, ram[a]);
                xf_cnt++;
                poly_xf++;
                if (dphase == 0 && mpoly < lens.size() && poly_xf == 4 * lens[mpoly]) begin
                    dphase   = 1;
                    wait_cnt = $urandom_range(0, 3);
                end
            end
            prev_stall = dec_valid && !dec_ready;
            prev_bytes = dec_ibytes;
            if (coeffs_valid) begin
                if (exp_q.size() == 0) begin
                    check("coef_extra", 64'(coeffs_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("coef_data", coeffs, e.d);
                    check("coef_poly", 64'(poly_idx), 64'(e.p));
                    check("coef_word", 64'(word_idx), 64'(e.w));
                    coef_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_time", 64'(cyc), legal ? 64'(done_cyc + 2) : 64'd2);
                if (seen_done_at < 0) seen_done_at = cyc;
            end
            if (done_now) begin
                mpoly++;
                poly_xf = 0; em_cnt = 0; didx = 0;
                done_cyc = cyc;
                if (mpoly < lens.size()) begin
                    dphase = 0; gap_pending = 1; gap_ref = cyc;
                end else begin
                    dphase = 3;
                end
            end
            if (abort && mpoly == 1 && poly_xf == 5) begin
                #2;
                rst = 1'b1;
                dec_ready = 1'b0; dec_cv = 1'b0; dec_done = 1'b0; dec_coeffs = '0;
                #1;
                check_zero("abort");
                check("abort_no_done", 64'(done_cnt), 64'd0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                $display("OBJ mode=%0d k=%0d base=%02h aborted at cycle %0d after %0d xfers",
                         m, kk, b, cyc, xf_cnt);
                return;
            end
            if (seen_done_at >= 0 && cyc >= seen_done_at + 2) break;
        end

        check("reads", 64'(rd_cnt), 64'(total));
        check("xfers", 64'(xf_cnt), 64'(total));
        check("done_count", 64'(done_cnt), 64'd1);
        check("coef_left", 64'(exp_q.size()), 64'd0);
        check("coef_count", 64'(coef_cnt), 64'(NC * lens.size()));
        check("err_flag", 64'(err), 64'(!legal));
        check("busy_end", 64'(busy), 64'd0);
        $display("OBJ mode=%0d k=%0d du=%0d dv=%0d base=%02h reads=%0d xfers=%0d coeffs=%0d err=%0d",
                 m, kk, u, v, b, rd_cnt, xf_cnt, coef_cnt, err);
    endtask

    initial begin
        start = 1'b0; mode = '0; k = '0; du = 1'b0; dv = 1'b0; base = '0;
        dec_ready = 1'b0; dec_coeffs = '0; dec_cv = 1'b0; dec_done = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = {$urandom(), $urandom()};

        #1 rst = 1'b1;
        #1 check_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_obj(2'd2, 3'd2, 1'b0, 1'b0, 8'h10, 0, 0);
        run_obj(2'd0, 3'd3, 1'b0, 1'b0, 8'h20, 1, 0);
        run_obj(2'd1, 3'd2, 1'b1, 1'b0, 8'hF0, 1, 0);
        run_obj(2'd3, 3'd2, 1'b0, 1'b0, 8'h00, 1, 0);
        run_obj(2'd2, 3'd2, 1'b0, 1'b0, 8'h05, 1, 0);
        run_obj(2'd0, 3'd1, 1'b0, 1'b0, 8'h00, 1, 0);
        run_obj(2'd1, 3'd4, 1'b1, 1'b1, 8'h30, 1, 1);
        run_obj(2'd1, 3'd4, 1'b1, 1'b1, 8'h30, 1, 0);
        for (int t = 0; t < 4; t++) begin
            run_obj(2'($urandom_range(0, 2)), 3'($urandom_range(2, 4)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
